// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the alu arbiter: alu control codes, FSM states
// and a small id-to-one-hot helper.
package alu_arbiter_pkg;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   function automatic logic [1:0] id_onehot(input logic id);
      return id ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational alu shared by both requesters; slt is a signed compare and
// undefined control codes produce zero.
module alu_arbiter_alu
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [2:0]       control_i,
   output logic [WIDTH-1:0] result_o,
   output logic             zero_o
);

   logic [WIDTH-1:0] result_s;

   // Operation select
   always_comb begin
      result_s = '0;
      case (control_i)
         ALU_AND: result_s = a_i & b_i;
         ALU_OR:  result_s = a_i | b_i;
         ALU_ADD: result_s = a_i + b_i;
         ALU_SUB: result_s = a_i - b_i;
         ALU_SLT: result_s = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
         default: result_s = '0;
      endcase
   end

   assign result_o = result_s;
   assign zero_o   = (result_s == '0);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one alu between two requesters, with
// valid/ready handshakes on both sides and one operation in flight.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [WIDTH-1:0] req_a0,
   input  logic [WIDTH-1:0] req_b0,
   input  logic [2:0]       req_ctrl0,
   input  logic [WIDTH-1:0] req_a1,
   input  logic [WIDTH-1:0] req_b1,
   input  logic [2:0]       req_ctrl1,
   output logic [1:0]       rsp_valid,
   input  logic [1:0]       rsp_ready,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_zero,
   output logic             busy
);

   state_e           state_q;
   logic             id_q;
   logic             last_grant_q;
   logic [WIDTH-1:0] a_q, b_q;
   logic [2:0]       ctrl_q;
   logic [WIDTH-1:0] rsp_result_q;
   logic             rsp_zero_q;
   logic [1:0]       rsp_valid_q;
   logic             busy_q;

   logic             grant_s;
   logic [1:0]       req_ready_s;
   logic [WIDTH-1:0] a_d, b_d;
   logic [2:0]       ctrl_d;
   logic [WIDTH-1:0] alu_result_s;
   logic             alu_zero_s;

   // Grant selection; on contention the requester not served last wins
   always_comb begin
      grant_s     = 1'b0;
      req_ready_s = 2'b00;
      case (req_valid)
         2'b01:   grant_s = 1'b0;
         2'b10:   grant_s = 1'b1;
         2'b11:   grant_s = ~last_grant_q;
         default: grant_s = 1'b0;
      endcase
      if ((state_q == ST_IDLE) && (req_valid != 2'b00)) begin
         req_ready_s = id_onehot(grant_s);
      end else begin
         req_ready_s = 2'b00;
      end
   end

   // Operand mux feeding the operand registers
   always_comb begin
      a_d    = a_q;
      b_d    = b_q;
      ctrl_d = ctrl_q;
      if (grant_s) begin
         a_d    = req_a1;
         b_d    = req_b1;
         ctrl_d = req_ctrl1;
      end else begin
         a_d    = req_a0;
         b_d    = req_b0;
         ctrl_d = req_ctrl0;
      end
   end

   alu_arbiter_alu #(.WIDTH(WIDTH)) u_alu (
      .a_i       (a_q),
      .b_i       (b_q),
      .control_i (ctrl_q),
      .result_o  (alu_result_s),
      .zero_o    (alu_zero_s)
   );

   // Arbitration FSM with registered response and busy outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         id_q         <= 1'b0;
         last_grant_q <= 1'b1;
         a_q          <= '0;
         b_q          <= '0;
         ctrl_q       <= 3'b000;
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_valid_q  <= 2'b00;
         busy_q       <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_ready_s != 2'b00) begin
                  a_q          <= a_d;
                  b_q          <= b_d;
                  ctrl_q       <= ctrl_d;
                  id_q         <= grant_s;
                  last_grant_q <= grant_s;
                  busy_q       <= 1'b1;
                  state_q      <= ST_EXEC;
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_EXEC: begin
               rsp_result_q <= alu_result_s;
               rsp_zero_q   <= alu_zero_s;
               rsp_valid_q  <= id_onehot(id_q);
               state_q      <= ST_RESP;
            end
            ST_RESP: begin
               if (rsp_ready[id_q]) begin
                  rsp_valid_q <= 2'b00;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end else begin
                  state_q <= ST_RESP;
               end
            end
            default: begin
               rsp_valid_q <= 2'b00;
               busy_q      <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_ready  = req_ready_s;
   assign rsp_valid  = rsp_valid_q;
   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized and directed bench for alu_arbiter against a transaction-level
// model of the arbitration rule and the alu arithmetic.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
   logic [31:0] req_a0, req_b0, req_a1, req_b1, rsp_result;
   logic [2:0]  req_ctrl0, req_ctrl1;
   logic        rsp_zero, busy;

   int n_vec = 0;
   int n_err = 0;

   logic        pend [2];
   logic [31:0] pa [2];
   logic [31:0] pb [2];
   logic [2:0]  pc [2];
   int          last_g;

   always #5 clk = ~clk;

   alu_arbiter #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a0(req_a0), .req_b0(req_b0), .req_ctrl0(req_ctrl0),
      .req_a1(req_a1), .req_b1(req_b1), .req_ctrl1(req_ctrl1),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .busy(busy)
   );

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference alu: {zero, result}
   function automatic logic [32:0] ref_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      int sa, sb;
      sa = a;
      sb = b;
      case (c)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a + b;
         3'b110:  r = a - b;
         3'b111:  r = (sa < sb) ? 32'd1 : 32'd0;
         default: r = 32'd0;
      endcase
      return {(r == 32'd0), r};
   endfunction

   task automatic drive_reqs();
      req_valid = {pend[1], pend[0]};
      req_a0 = pa[0]; req_b0 = pb[0]; req_ctrl0 = pc[0];
      req_a1 = pa[1]; req_b1 = pb[1]; req_ctrl1 = pc[1];
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
      pend[i] = 1'b1; pa[i] = a; pb[i] = b; pc[i] = c;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      pend[0] = 1'b0; pend[1] = 1'b0;
      drive_reqs();
      rsp_ready = 2'b00;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      last_g = 1;
   endtask

   // One arbitration round: called at a negedge in IDLE, returns at a later negedge + 1
   task automatic serve(input int stall);
      int          g;
      logic [1:0]  oh, other;
      logic [32:0] exp;
      drive_reqs();
      rsp_ready = 2'b00;
      #1;
      if (pend[0] && pend[1]) g = (last_g == 1) ? 0 : 1;
      else g = pend[1] ? 1 : 0;
      oh  = (g == 1) ? 2'b10 : 2'b01;
      exp = ref_alu(pc[g], pa[g], pb[g]);
      check_eq("idle_busy", busy, 1'b0);
      check_eq("idle_rsp_valid", rsp_valid, 2'b00);
      check_eq("grant", req_ready, oh);
      @(negedge clk);
      pend[g] = 1'b0;
      last_g  = g;
      pa[g] = $urandom; pb[g] = $urandom;
      drive_reqs();
      #1;
      check_eq("exec_busy", busy, 1'b1);
      check_eq("exec_req_ready", req_ready, 2'b00);
      check_eq("exec_rsp_valid", rsp_valid, 2'b00);
      @(negedge clk);
      for (int s = 0; s <= stall; s++) begin
         other = ($urandom_range(0, 1) == 1) ? ~oh : 2'b00;
         rsp_ready = (s == stall) ? (oh | other) : other;
         #1;
         check_eq("rsp_valid", rsp_valid, oh);
         check_eq("rsp_result", rsp_result, exp[31:0]);
         check_eq("rsp_zero", rsp_zero, exp[32]);
         check_eq("rsp_busy", busy, 1'b1);
         check_eq("rsp_req_ready", req_ready, 2'b00);
         @(negedge clk);
      end
      rsp_ready = 2'b00;
      #1;
      check_eq("done_busy", busy, 1'b0);
      check_eq("done_rsp_valid", rsp_valid, 2'b00);
   endtask

   function automatic logic [2:0] rand_ctrl();
      logic [2:0] codes [5];
      codes[0] = 3'b000; codes[1] = 3'b001; codes[2] = 3'b010;
      codes[3] = 3'b110; codes[4] = 3'b111;
      return codes[$urandom_range(0, 4)];
   endfunction

   initial begin
      pend[0] = 1'b0; pend[1] = 1'b0;
      for (int i = 0; i < 2; i++) begin pa[i] = 32'd0; pb[i] = 32'd0; pc[i] = 3'b000; end
      rst = 1'b1;
      drive_reqs();
      rsp_ready = 2'b00;
      @(negedge clk);
      #1;
      check_eq("reset_rsp_valid", rsp_valid, 2'b00);
      check_eq("reset_busy", busy, 1'b0);
      check_eq("reset_result", rsp_result, 32'd0);
      check_eq("reset_zero", rsp_zero, 1'b0);
      check_eq("reset_req_ready", req_ready, 2'b00);
      do_reset();

      // basic add and sub-to-zero
      set_req(0, 32'd5, 32'd7, 3'b010);  serve(0);
      set_req(1, 32'd9, 32'd9, 3'b110);  serve(0);

      // contention straight after reset, then again
      do_reset();
      set_req(0, 32'h0000_F0F0, 32'h0000_FF00, 3'b000);
      set_req(1, 32'h0000_000F, 32'h0000_00F0, 3'b001);
      serve(0); serve(0);
      set_req(0, 32'h0000_F0F0, 32'h0000_FF00, 3'b000);
      set_req(1, 32'h0000_000F, 32'h0000_00F0, 3'b001);
      serve(0); serve(0);

      // backpressure and signed slt
      set_req(0, 32'd100, 32'd23, 3'b010); serve(5);
      set_req(0, 32'hFFFF_FFFF, 32'd1, 3'b111); serve(0);

      // reset while the operation is in EXEC
      set_req(0, 32'd40, 32'd2, 3'b010);
      drive_reqs();
      #1;
      check_eq("rst_grant", req_ready, 2'b01);
      @(negedge clk);
      pend[0] = 1'b0;
      drive_reqs();
      rst = 1'b1;
      #1;
      check_eq("rst_mid_rsp_valid", rsp_valid, 2'b00);
      check_eq("rst_mid_busy", busy, 1'b0);
      check_eq("rst_mid_result", rsp_result, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      last_g = 1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         #1;
         check_eq("rst_no_rsp", rsp_valid, 2'b00);
         check_eq("rst_no_busy", busy, 1'b0);
      end
      set_req(0, 32'd40, 32'd2, 3'b010); serve(0);

      // randomized traffic
      for (int t = 0; t < 200; t++) begin
         for (int i = 0; i < 2; i++) begin
            if (!pend[i] && ($urandom_range(0, 9) < 6)) begin
               pa[i] = $urandom;
               pb[i] = ($urandom_range(0, 4) == 0) ? pa[i] : $urandom;
               if ($urandom_range(0, 3) == 0) pb[i] = {{31{1'b0}}, pb[i][0]};
               pc[i] = rand_ctrl();
               pend[i] = 1'b1;
            end
         end
         if (!pend[0] && !pend[1]) begin
            drive_reqs();
            #1;
            check_eq("idle_req_ready", req_ready, 2'b00);
            check_eq("idle_busy_rand", busy, 1'b0);
            @(negedge clk);
         end else begin
            serve($urandom_range(0, 3));
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
